// File: rtl/acc_store_unit_pkg.sv
// Shared CPU definitions for the accumulator store path: bus widths,
// store FSM encoding and the store-queue entry layout.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Address in the upper bits so {addr,data} concatenations line up with the struct
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_entry_t;

endpackage

// File: rtl/acc_store_unit_if.sv
// Signal bundle between control unit / memory port (master) and the store unit (slave).
interface acc_store_unit_if;
  import cpu_pkg::*;

  // Store strobe: C_ST is a one-cycle request with ACC_NUM/MAR_ADDR valid in the same
  // cycle; there is no ready, the caller must respect st_full. Memory write: mem_req
  // rises with mem_addr/mem_wdata and they stay constant until the cycle mem_ack is
  // seen high (or the unit gives up); mem_ack outside a request is ignored.
  logic              C_ST;
  logic [DATA_W-1:0] ACC_NUM;
  logic [ADDR_W-1:0] MAR_ADDR;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              st_full;
  logic              st_busy;
  logic              st_done;
  logic              st_ovf;
  logic              st_tmo;
  state_t            dbg_state;

  modport master (
    output C_ST, ACC_NUM, MAR_ADDR, mem_ack,
    input  mem_req, mem_addr, mem_wdata, st_full, st_busy, st_done, st_ovf, st_tmo,
           dbg_state
  );

  modport slave (
    input  C_ST, ACC_NUM, MAR_ADDR, mem_ack,
    output mem_req, mem_addr, mem_wdata, st_full, st_busy, st_done, st_ovf, st_tmo,
           dbg_state
  );

endinterface

// File: rtl/acc_store_unit_store_fifo.sv
// Store queue: DEPTH entries of {addr,data}, first-word-fall-through head.
module store_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  st_entry_t                  din,
  input  logic                       pop,
  output st_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  st_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_store_unit.sv
// Accumulator store unit: queues {MAR,ACC} on C_ST and drains the queue to memory
// over req/ack, one write at a time, with a per-write timeout.
module acc_store_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  acc_store_unit_if.slave    bus
);

  localparam int TW = $clog2(TIMEOUT+1);
  localparam int CW = $clog2(DEPTH+1);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic              req_q, done_q, ovf_q, tmo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  st_entry_t         head;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              push, pop, load, ack_pop, tmo_pop;

  assign push = bus.C_ST && !full;
  assign pop  = ack_pop || tmo_pop;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.MAR_ADDR, bus.ACC_NUM}),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // The head entry stays in the queue until its write finishes or is abandoned
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ack_pop = 1'b0;
    tmo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          ack_pop = 1'b1;
          state_d = ST_GAP;
        end else if (timer_q == TW'(TIMEOUT)) begin
          tmo_pop = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= ack_pop;
      if (bus.C_ST && full) ovf_q <= 1'b1;
      if (tmo_pop)          tmo_q <= 1'b1;
      if (load) begin
        req_q   <= 1'b1;
        addr_q  <= head.addr;
        data_q  <= head.data;
        timer_q <= '0;
      end else if (pop) begin
        req_q   <= 1'b0;
      end else if (state_q == ST_REQ) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;
  assign bus.st_done   = done_q;
  assign bus.st_ovf    = ovf_q;
  assign bus.st_tmo    = tmo_q;
  assign bus.st_full   = full;
  assign bus.st_busy   = (count != '0) || (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_acc_store_unit.sv
// Bench for acc_store_unit: directed scenarios plus random traffic, checked by a
// cycle-level reference model and an expected-write queue.
module tb_acc_store_unit;
  import cpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  acc_store_unit_if bus ();

  acc_store_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // memory responder controls
  int   ack_mode  = 0;   // 0 never, 1 after ack_delay req cycles, 2 manual, 3 random
  int   ack_delay = 0;
  logic man_ack   = 1'b0;
  int   req_run   = 0;

  // reference model state
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int   pcyc_q[$];
  int   cyc       = 0;
  int   earliest  = 0;
  int   gap_cyc   = -1;
  int   req_cnt   = 0;
  int   pre;
  bit   started   = 0;
  bit   after_rst = 0;
  bit   m_ovf = 0, m_tmo = 0, m_done = 0;
  bit   exp_req;
  bit   popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // memory side: acknowledge according to the selected mode
  always @(posedge clk) begin
    #2;
    case (ack_mode)
      0:       bus.mem_ack = 1'b0;
      1:       bus.mem_ack = bus.mem_req && (req_run >= ack_delay);
      2:       bus.mem_ack = man_ack;
      default: bus.mem_ack = ($urandom_range(0, 3) == 0);
    endcase
    req_run = (bus.mem_req === 1'b1) ? req_run + 1 : 0;
  end

  // monitor + model: compare this cycle's outputs, then advance the model past the next edge
  always @(negedge clk) begin
    exp_req = (exp_q.size() != 0) && (cyc >= earliest) && (cyc >= pcyc_q[0] + 2);
    if (started) begin
      chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
      chk("st_done", 32'(bus.st_done), 32'(m_done));
      chk("st_ovf",  32'(bus.st_ovf),  32'(m_ovf));
      chk("st_tmo",  32'(bus.st_tmo),  32'(m_tmo));
      chk("st_full", 32'(bus.st_full), 32'(exp_q.size() == DEPTH));
      chk("st_busy", 32'(bus.st_busy), 32'((exp_q.size() != 0) || (cyc == gap_cyc)));
      if (after_rst) begin
        chk("rst_addr_data", {8'h0, bus.mem_addr, bus.mem_wdata}, 32'h0);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      end
      if (exp_req && bus.mem_req === 1'b1)
        chk("write_addr_data", {8'h0, bus.mem_addr, bus.mem_wdata}, {8'h0, exp_q[0]});
    end

    if (rst) begin
      exp_q.delete();
      pcyc_q.delete();
      m_ovf = 0; m_tmo = 0; m_done = 0;
      req_cnt = 0; earliest = cyc + 1; gap_cyc = -1;
      after_rst = 1; started = 1;
    end else if (started) begin
      after_rst = 0;
      m_done = 0;
      popped = 0;
      pre = exp_q.size();
      if (exp_req) begin
        if (bus.mem_ack === 1'b1) begin
          m_done = 1; popped = 1;
        end else if (req_cnt == TIMEOUT) begin
          m_tmo = 1; popped = 1;
        end else begin
          req_cnt++;
        end
        if (popped) begin
          void'(exp_q.pop_front());
          void'(pcyc_q.pop_front());
          req_cnt  = 0;
          gap_cyc  = cyc + 1;
          earliest = cyc + 3;
        end
      end
      if (bus.C_ST === 1'b1) begin
        if (pre < DEPTH) begin
          exp_q.push_back({bus.MAR_ADDR, bus.ACC_NUM});
          pcyc_q.push_back(cyc);
        end else begin
          m_ovf = 1;
        end
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.C_ST = 1'b1; bus.MAR_ADDR = a; bus.ACC_NUM = d;
    step(1);
    bus.C_ST = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (bus.st_busy !== 1'b0 && k < limit) begin
      step(1);
      k++;
    end
    if (k >= limit) begin
      n_vec++; n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
    end
  endtask

  task automatic wait_req(input int limit);
    int k = 0;
    while (bus.mem_req !== 1'b1 && k < limit) begin
      step(1);
      k++;
    end
    if (k >= limit) begin
      n_vec++; n_bad++;
      $display("FAIL wait_req: no mem_req after %0d cycles, required 1", limit);
    end
  endtask

  initial begin
    // reset held with a store strobe active: nothing may be queued
    bus.C_ST = 1'b1; bus.ACC_NUM = 16'hdead; bus.MAR_ADDR = 8'h55;
    step(2);
    rst = 1'b0; bus.C_ST = 1'b0;
    step(2);

    // single store, ack three cycles into the request
    ack_mode = 1; ack_delay = 3;
    store(8'h20, 16'h1234);
    wait_idle(40);
    step(1);

    // fill to full and overflow with a fifth store
    ack_mode = 0;
    for (int i = 1; i <= 5; i++) store(8'($urandom_range(0, 255)), 16'(i));
    ack_mode = 1; ack_delay = 1;
    wait_idle(100);
    step(1);

    // push and pop in the same cycle with two entries queued
    ack_mode = 2; man_ack = 1'b0;
    store(8'h31, 16'haaaa);
    store(8'h32, 16'hbbbb);
    wait_req(10);
    man_ack = 1'b1;
    store(8'h33, 16'hcccc);
    man_ack = 1'b0;
    ack_mode = 1; ack_delay = $urandom_range(0, 4);
    wait_idle(100);
    step(1);

    // two writes that are never acknowledged
    ack_mode = 0;
    store(8'h40, 16'h0404);
    store(8'h41, 16'h0414);
    wait_idle(60);
    ack_mode = 1; ack_delay = 0;
    store(8'h42, 16'h0424);
    wait_idle(20);
    step(1);

    // reset in the middle of a write with a backlog
    ack_mode = 0;
    for (int i = 0; i < 3; i++) store(8'($urandom_range(0, 255)), 16'($urandom));
    wait_req(10);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);

    // random traffic against a random, sometimes spurious, acknowledge
    ack_mode = 3;
    repeat (400) begin
      bus.C_ST     = ($urandom_range(0, 2) == 0);
      bus.MAR_ADDR = 8'($urandom_range(0, 255));
      bus.ACC_NUM  = 16'($urandom);
      step(1);
    end
    bus.C_ST = 1'b0;
    ack_mode = 1; ack_delay = 2;
    wait_idle(300);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
